// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between icache refill (port 0) and dcache miss/writeback (port 1).
// Optional starvation limit on the priority port is enabled by defining ARB_STARVE_LIMIT_EN.
module mem_port_arbiter #(
  parameter int PRIO_DCACHE  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_rd_i,
  input  logic [31:0] m0_addr_i,
  input  logic [7:0]  m0_len_i,
  output logic        m0_accept_o,
  output logic        m0_valid_o,
  output logic [31:0] m0_data_o,
  output logic        m0_last_o,
  output logic        m0_error_o,
  input  logic        m1_rd_i,
  input  logic [3:0]  m1_wr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [7:0]  m1_len_i,
  input  logic [31:0] m1_data_wr_i,
  output logic        m1_accept_o,
  output logic        m1_valid_o,
  output logic [31:0] m1_data_o,
  output logic        m1_last_o,
  output logic        m1_error_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_len_o,
  output logic [31:0] mem_data_wr_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_rd_i,
  input  logic        mem_last_i,
  input  logic        mem_error_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic PRIO_PORT = (PRIO_DCACHE != 0);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..255");
  end

  state_e      state_r;
  logic        grant_r;
  logic        mem_rd_r;
  logic [3:0]  mem_wr_r;
  logic [31:0] mem_addr_r;
  logic [7:0]  mem_len_r;
  logic [31:0] mem_wdata_r;
  logic [7:0]  beat_cnt_r;

  logic        m0_req_s;
  logic        m1_req_s;
  logic        pick1_s;
  logic        grant_s;
  logic        force_s;
  logic        beat_s;

  assign mem_rd_o      = mem_rd_r;
  assign mem_wr_o      = mem_wr_r;
  assign mem_addr_o    = mem_addr_r;
  assign mem_len_o     = mem_len_r;
  assign mem_data_wr_o = mem_wdata_r;

  // Arbitration: pick a winner among requesting ports while idle
  always_comb begin
    m0_req_s = m0_rd_i;
    m1_req_s = m1_rd_i | (|m1_wr_i);
    if (m0_req_s && m1_req_s) begin
      pick1_s = PRIO_PORT ^ force_s;
    end else begin
      pick1_s = m1_req_s;
    end
    // Gating with rst_ni keeps the accept strobes low while reset is held
    grant_s     = rst_ni & (state_r == ST_IDLE) & (m0_req_s | m1_req_s);
    m0_accept_o = grant_s & ~pick1_s;
    m1_accept_o = grant_s & pick1_s;
  end

  // Response routing: beats reach only the granted port, and only in RESP
  always_comb begin
    beat_s     = (state_r == ST_RESP) & mem_valid_i;
    m0_valid_o = 1'b0;
    m0_data_o  = 32'h0000_0000;
    m0_last_o  = 1'b0;
    m0_error_o = 1'b0;
    m1_valid_o = 1'b0;
    m1_data_o  = 32'h0000_0000;
    m1_last_o  = 1'b0;
    m1_error_o = 1'b0;
    if (beat_s) begin
      if (grant_r) begin
        m1_valid_o = 1'b1;
        m1_data_o  = mem_data_rd_i;
        m1_last_o  = mem_last_i;
        m1_error_o = mem_error_i;
      end else begin
        m0_valid_o = 1'b1;
        m0_data_o  = mem_data_rd_i;
        m0_last_o  = mem_last_i;
        m0_error_o = mem_error_i;
      end
    end else begin
      m0_valid_o = 1'b0;
      m1_valid_o = 1'b0;
    end
  end

  // Transaction FSM with capture registers feeding the downstream request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      grant_r     <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 4'h0;
      mem_addr_r  <= 32'h0000_0000;
      mem_len_r   <= 8'h00;
      mem_wdata_r <= 32'h0000_0000;
      beat_cnt_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            grant_r <= pick1_s;
            state_r <= ST_REQ;
            if (!pick1_s) begin
              mem_rd_r    <= 1'b1;
              mem_wr_r    <= 4'h0;
              mem_addr_r  <= m0_addr_i;
              mem_len_r   <= m0_len_i;
              mem_wdata_r <= 32'h0000_0000;
            end else if (|m1_wr_i) begin
              // A write wins over a simultaneous read on port 1
              mem_rd_r    <= 1'b0;
              mem_wr_r    <= m1_wr_i;
              mem_addr_r  <= m1_addr_i;
              mem_len_r   <= 8'h00;
              mem_wdata_r <= m1_data_wr_i;
            end else begin
              mem_rd_r    <= 1'b1;
              mem_wr_r    <= 4'h0;
              mem_addr_r  <= m1_addr_i;
              mem_len_r   <= m1_len_i;
              mem_wdata_r <= 32'h0000_0000;
            end
          end
        end
        ST_REQ: begin
          if (mem_accept_i) begin
            mem_rd_r   <= 1'b0;
            mem_wr_r   <= 4'h0;
            beat_cnt_r <= 8'h00;
            state_r    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_valid_i) begin
            beat_cnt_r <= beat_cnt_r + 8'h01;
            if (mem_last_i) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_rd_r <= 1'b0;
          mem_wr_r <= 4'h0;
        end
      endcase
    end
  end

`ifdef ARB_STARVE_LIMIT_EN
  logic [7:0] starve_cnt_r;

  assign force_s = (starve_cnt_r >= 8'(STARVE_LIMIT));

  // Starvation counter: contested wins by the priority port since the other port last won
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_r <= 8'h00;
    end else if (grant_s) begin
      if (pick1_s != PRIO_PORT) begin
        starve_cnt_r <= 8'h00;
      end else if (m0_req_s && m1_req_s && (starve_cnt_r != 8'hFF)) begin
        starve_cnt_r <= starve_cnt_r + 8'h01;
      end
    end
  end
`else
  assign force_s = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory read/write port between the instruction-cache refill path (port 0) and the data-cache miss/writeback path (port 1).
- One transaction is in flight at a time.
- The granted requester is locked from request acceptance until its final response beat.
- Sits between the icache/dcache miss handlers and the bus interface. It sequences the burst refills that ultimately satisfy fetch-stage icache reads.

Parameters:
- PRIO_DCACHE, 1, on simultaneous requests in IDLE: 1 = port 1 wins, 0 = port 0 wins.
- STARVE_LIMIT, 8, consecutive wins by the priority port before the other port is forced to win (used only with ARB_STARVE_LIMIT_EN).

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- m0_rd_i  in  1  icache refill read request
- m0_addr_i  in  32  refill address, 16-byte aligned
- m0_len_i  in  8  burst beats minus one
- m0_accept_o  out  1  request captured this cycle
- m0_valid_o  out  1  response beat valid
- m0_data_o  out  32  response data
- m0_last_o  out  1  final beat
- m0_error_o  out  1  bus error on this beat
- m1_rd_i  in  1  dcache read request
- m1_wr_i  in  4  dcache write byte strobes, single beat
- m1_addr_i  in  32  address
- m1_len_i  in  8  read beats minus one (ignored for writes)
- m1_data_wr_i  in  32  write data
- m1_accept_o, m1_valid_o, m1_data_o, m1_last_o, m1_error_o: as port 0
- mem_rd_o  out  1  downstream read request
- mem_wr_o  out  4  downstream write strobes
- mem_addr_o  out  32  downstream address
- mem_len_o  out  8  downstream beats minus one
- mem_data_wr_o  out  32  downstream write data
- mem_accept_i  in  1  downstream request accepted
- mem_valid_i  in  1  response beat valid (write ack = single beat)
- mem_data_rd_i  in  32  response data
- mem_last_i  in  1  final response beat
- mem_error_i  in  1  response error

Behaviour:
- Reset (rst_ni low, async):
  - State IDLE; grant register, capture registers and starvation counter cleared.
  - All outputs 0.
  - A reset mid-transaction abandons it; no further beats are forwarded.
- FSM IDLE:
  - A port requests if m0_rd_i, or if m1_rd_i or |m1_wr_i.
  - The winner is chosen combinationally by PRIO_DCACHE; mX_accept_o is high for that cycle only.
  - addr/len/strobes/data are captured into registers, the grant is latched, and the FSM moves to REQ.
  - m1 with both rd and wr set: treated as a write; rd ignored.
- FSM REQ:
  - mem_rd_o/mem_wr_o/mem_addr_o/mem_len_o/mem_data_wr_o are driven from the capture registers and held stable until mem_accept_i.
  - On accept, the FSM moves to RESP. Writes force mem_len_o = 0.
- FSM RESP:
  - mem_valid_i/data/last/error are routed combinationally to the granted port only. The other port's valid_o stays 0.
  - On mem_valid_i & mem_last_i, the FSM returns to IDLE. This gives one idle bubble: earliest next grant is the cycle after last.
- Latency: request cycle N → accept N → mem_rd_o first asserted N+1.
- Stray mem_valid_i in IDLE or REQ is discarded and not forwarded.
- Requester inputs are ignored outside IDLE. Requesters hold their request until accepted.
- The beat counter (8-bit) increments per forwarded beat and clears on entering RESP. mX_last_o = mem_last_i; the counter is exposed only for assertions: the count at last must equal the latched len.
- mem_error_i is forwarded per beat. It does not abort the burst; the FSM still waits for last.

Optional Feature:
- Macro ARB_STARVE_LIMIT_EN.
- Defined:
  - The starvation counter counts consecutive grants to the priority port that occur while the other port is also requesting.
  - When the count reaches STARVE_LIMIT, the next IDLE arbitration grants the non-priority port if it is requesting, and the counter clears.
  - The counter also clears on any grant to the non-priority port.
- Not defined: pure fixed priority; the counter logic is absent.

Test Plan:
- Single icache refill: m0_rd_i=1, addr 0x1000, len 3, mem_accept_i after 2 cycles, 4 beats → m0_accept_o pulses once; mem_addr_o=0x1000, mem_len_o=3 held 2 cycles; m0 gets 4 valids with last on beat 4; m1_valid_o=0.
- Simultaneous m0_rd_i and m1_wr_i=4'hF (PRIO_DCACHE=1), write data 0xDEADBEEF → m1 accepted first; mem_wr_o=4'hF, mem_len_o=0; after write ack, m0 is accepted exactly 1 cycle later.
- Error beat: port 0 burst len 3 with mem_error_i on beat 2 → m0_error_o high only on beat 2; FSM returns to IDLE only after the last beat.
- Reset asserted in RESP after beat 1 of 4 → all outputs 0 immediately; remaining mem_valid_i beats after reset release are discarded; new m0 request then granted normally.
- With ARB_STARVE_LIMIT_EN, STARVE_LIMIT=2: m0 and m1 continuously requesting → grant order m1, m1, m0, m1, m1, m0. Without the macro → m1 always.
